ipsxe_floating_point_sqrt_iter_v1_0: RTL and testbench

Iterative, handshaked mantissa square-root engine for the floating-point sqrt datapath. It accepts a significand and its exponent parity, then forms the aligned radicand internally. It computes an exact floor square root plus a sticky bit over a configurable number of cycles, trading latency for area through BITS_PER_CYCLE. It sits between exponent handling (which supplies parity and compensates the exponent) and the rounding stage.

---
 rtl/ipsxe_floating_point_sqrt_iter_v1_0.sv | 131 +++++++++++++
 tb/tb_ipsxe_floating_point_sqrt_iter_v1_0.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxe_floating_point_sqrt_iter_v1_0.sv
// Iterative restoring square root of an aligned significand, BITS_PER_CYCLE root
// bits per clock, with valid/ready handshakes on both sides and a sideband tag.
module ipsxe_floating_point_sqrt_iter_v1_0 #(
  parameter int unsigned MANTISSA_SIZE  = 52,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_is_exp_odd,
  input  logic [MANTISSA_SIZE-1:0] i_man,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [MANTISSA_SIZE+1:0] o_root,
  output logic                     o_sticky,
  output logic [TAG_W-1:0]         o_tag
);

  localparam int unsigned ROOT_W = MANTISSA_SIZE + 2;
  localparam int unsigned RAD_W  = 2 * ROOT_W;
  localparam int unsigned REM_W  = ROOT_W + 2;
  localparam int unsigned WIDE_W = REM_W + 2;
  localparam int unsigned ITER   = ROOT_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = $clog2(ITER + 1);

  if ((ROOT_W % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("MANTISSA_SIZE+2 must be divisible by BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state;
  logic [RAD_W-1:0]   rad_q;
  logic [REM_W-1:0]   rem_q;
  logic [ROOT_W-1:0]  root_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TAG_W-1:0]   tag_q;

  logic [ROOT_W-1:0]  align_c;
  logic [RAD_W-1:0]   rad_n;
  logic [REM_W-1:0]   rem_n;
  logic [ROOT_W-1:0]  root_n;
  logic [WIDE_W-1:0]  wide;
  logic [WIDE_W-1:0]  trial;

  // Odd exponents keep the significand in [1,2), even ones double it into [2,4).
  assign align_c = i_is_exp_odd ? {2'b01, i_man} : {1'b1, i_man, 1'b0};

  // BITS_PER_CYCLE unrolled restoring steps, each consuming two radicand bits.
  always_comb begin
    rad_n  = rad_q;
    rem_n  = rem_q;
    root_n = root_q;
    wide   = '0;
    trial  = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      wide  = {rem_n, rad_n[RAD_W-1 -: 2]};
      trial = WIDE_W'({root_n, 2'b01});
      if (wide >= trial) begin
        wide   = wide - trial;
        root_n = {root_n[ROOT_W-2:0], 1'b1};
      end else begin
        root_n = {root_n[ROOT_W-2:0], 1'b0};
      end
      rem_n = REM_W'(wide);
      rad_n = {rad_n[RAD_W-3:0], 2'b00};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
      o_ready  <= 1'b0;
      o_valid  <= 1'b0;
      o_root   <= '0;
      o_sticky <= 1'b0;
      o_tag    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (o_ready && i_valid) begin
            rad_q   <= {align_c, ROOT_W'(0)};
            rem_q   <= '0;
            root_q  <= '0;
            tag_q   <= i_tag;
            cnt_q   <= CNT_W'(ITER);
            o_ready <= 1'b0;
            state   <= S_BUSY;
          end else begin
            o_ready <= 1'b1;
          end
        end
        S_BUSY: begin
          rad_q  <= rad_n;
          rem_q  <= rem_n;
          root_q <= root_n;
          cnt_q  <= cnt_q - CNT_W'(1);
          // All radicand bits are consumed here, so the remainder is exact.
          if (cnt_q == CNT_W'(1)) begin
            o_valid  <= 1'b1;
            o_root   <= root_n;
            o_sticky <= |rem_n;
            o_tag    <= tag_q;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_sqrt_iter_v1_0.sv
// Scoreboard bench: a narrow M=4 engine for directed/handshake/reset scenarios and
// an M=52, 3-bits-per-cycle engine checked against a greedy square-root model.
module tb_ipsxe_floating_point_sqrt_iter_v1_0;

  localparam int unsigned TAG_W  = 8;
  localparam int unsigned M_S    = 4;
  localparam int unsigned RW_S   = 6;
  localparam int          ITER_S = 6;
  localparam int unsigned M_W    = 52;
  localparam int unsigned RW_W   = 54;
  localparam int unsigned BPC_W  = 3;
  localparam int          ITER_W = 18;
  localparam int          TMO    = 200;
  localparam int          N_RAND = 1200;

  typedef struct packed {
    logic [63:0]      root;
    logic             sticky;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             v_s = 1'b0, rdy_s, odd_s = 1'b0, ov_s, ir_s = 1'b1, st_s;
  logic [M_S-1:0]   man_s = '0;
  logic [TAG_W-1:0] tag_s = '0, otag_s;
  logic [RW_S-1:0]  root_s;

  logic             v_w = 1'b0, rdy_w, odd_w = 1'b0, ov_w, ir_w = 1'b1, st_w;
  logic [M_W-1:0]   man_w = '0;
  logic [TAG_W-1:0] tag_w = '0, otag_w;
  logic [RW_W-1:0]  root_w;

  exp_t q_s[$];
  exp_t q_w[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ipsxe_floating_point_sqrt_iter_v1_0 #(
    .MANTISSA_SIZE(M_S), .BITS_PER_CYCLE(1), .TAG_W(TAG_W)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_valid(v_s), .o_ready(rdy_s),
    .i_is_exp_odd(odd_s), .i_man(man_s), .i_tag(tag_s),
    .o_valid(ov_s), .i_ready(ir_s), .o_root(root_s), .o_sticky(st_s), .o_tag(otag_s)
  );

  ipsxe_floating_point_sqrt_iter_v1_0 #(
    .MANTISSA_SIZE(M_W), .BITS_PER_CYCLE(BPC_W), .TAG_W(TAG_W)
  ) dut_w (
    .i_clk(clk), .i_rst(rst), .i_valid(v_w), .o_ready(rdy_w),
    .i_is_exp_odd(odd_w), .i_man(man_w), .i_tag(tag_w),
    .o_valid(ov_w), .i_ready(ir_w), .o_root(root_w), .o_sticky(st_w), .o_tag(otag_w)
  );

  function automatic logic [127:0] ref_rad(input int m, input logic odd, input logic [63:0] man);
    logic [127:0] a;
    if (odd) a = (128'd1 << m) | 128'(man);
    else     a = (128'd1 << (m + 1)) | (128'(man) << 1);
    return a << (m + 2);
  endfunction

  // Greedy bit-by-bit floor square root using full-width squaring.
  function automatic logic [127:0] ref_root(input int m, input logic [127:0] r);
    logic [127:0] q;
    logic [127:0] c;
    q = '0;
    for (int b = m + 1; b >= 0; b--) begin
      c = q | (128'd1 << b);
      if (c * c <= r) q = c;
    end
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_s(input logic odd, input logic [M_S-1:0] man, input logic [TAG_W-1:0] tag,
                        input logic [63:0] root, input logic sticky, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (!rdy_s && n < TMO) begin step(); n++; end
    n_checks++;
    if (rdy_s !== 1'b1) begin
      n_fail++;
      $display("FAIL send_s_ready: o_ready=%0b required 1", rdy_s);
    end
    odd_s = odd; man_s = man; tag_s = tag; v_s = 1'b1;
    step();
    v_s = 1'b0;
    e.root = root; e.sticky = sticky; e.tag = tag;
    if (push) q_s.push_back(e);
  endtask

  task automatic recv_s(input int lat_req);
    int   n;
    exp_t e;
    n = 0;
    while (!ov_s && n < TMO) begin step(); n++; end
    n_checks++;
    if (ov_s !== 1'b1) begin
      n_fail++;
      $display("FAIL recv_s_valid: o_valid=%0b required 1 after %0d cycles", ov_s, n);
    end
    if (lat_req >= 0) begin
      n_checks++;
      if (n !== lat_req) begin
        n_fail++;
        $display("FAIL recv_s_latency: got %0d cycles required %0d", n, lat_req);
      end
    end
    if (q_s.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL recv_s_queue: result with empty scoreboard");
    end else begin
      e = q_s.pop_front();
      n_checks++;
      if (root_s !== e.root[RW_S-1:0]) begin
        n_fail++;
        $display("FAIL recv_s_root: got %0d required %0d", root_s, e.root[RW_S-1:0]);
      end
      n_checks++;
      if (st_s !== e.sticky || otag_s !== e.tag) begin
        n_fail++;
        $display("FAIL recv_s_sticky_tag: got %0b/%h required %0b/%h", st_s, otag_s, e.sticky, e.tag);
      end
    end
    step();
  endtask

  task automatic send_w(input logic odd, input logic [M_W-1:0] man, input logic [TAG_W-1:0] tag);
    int           n;
    exp_t         e;
    logic [127:0] r;
    logic [127:0] q;
    n = 0;
    while (!rdy_w && n < TMO) begin step(); n++; end
    n_checks++;
    if (rdy_w !== 1'b1) begin
      n_fail++;
      $display("FAIL send_w_ready: o_ready=%0b required 1", rdy_w);
    end
    odd_w = odd; man_w = man; tag_w = tag; v_w = 1'b1;
    step();
    v_w = 1'b0;
    r = ref_rad(int'(M_W), odd, 64'(man));
    q = ref_root(int'(M_W), r);
    e.root = q[63:0]; e.sticky = (r != q * q); e.tag = tag;
    q_w.push_back(e);
  endtask

  task automatic recv_w(input int lat_req);
    int   n;
    exp_t e;
    n = 0;
    while (!ov_w && n < TMO) begin step(); n++; end
    n_checks++;
    if (ov_w !== 1'b1 || n !== lat_req) begin
      n_fail++;
      $display("FAIL recv_w_valid: o_valid=%0b after %0d cycles required 1 after %0d", ov_w, n, lat_req);
    end
    if (q_w.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL recv_w_queue: result with empty scoreboard");
    end else begin
      e = q_w.pop_front();
      n_checks++;
      if (root_w !== e.root[RW_W-1:0] || st_w !== e.sticky || otag_w !== e.tag) begin
        n_fail++;
        $display("FAIL recv_w_result: got %h/%0b/%h required %h/%0b/%h",
                 root_w, st_w, otag_w, e.root[RW_W-1:0], e.sticky, e.tag);
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if (rdy_s !== 1'b0 || ov_s !== 1'b0 || root_s !== '0 || st_s !== 1'b0 || otag_s !== '0) begin
      n_fail++;
      $display("FAIL reset_s: rdy=%0b ov=%0b root=%0d st=%0b tag=%h required all 0",
               rdy_s, ov_s, root_s, st_s, otag_s);
    end
    n_checks++;
    if (rdy_w !== 1'b0 || ov_w !== 1'b0 || root_w !== '0 || st_w !== 1'b0 || otag_w !== '0) begin
      n_fail++;
      $display("FAIL reset_w: rdy=%0b ov=%0b root=%h st=%0b tag=%h required all 0",
               rdy_w, ov_w, root_w, st_w, otag_w);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (rdy_s !== 1'b1 || rdy_w !== 1'b1 || ov_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy_s=%0b rdy_w=%0b ov_s=%0b required 1/1/0", rdy_s, rdy_w, ov_s);
    end
  endtask

  task automatic test_directed();
    send_s(1'b1, 4'b0000, 8'h11, 64'd32, 1'b0, 1'b1); recv_s(ITER_S);
    send_s(1'b0, 4'b0000, 8'h22, 64'd45, 1'b1, 1'b1); recv_s(ITER_S);
    send_s(1'b1, 4'b1000, 8'h33, 64'd39, 1'b1, 1'b1); recv_s(ITER_S);
    send_s(1'b0, 4'b0010, 8'h44, 64'd48, 1'b0, 1'b1); recv_s(ITER_S);
    send_s(1'b0, 4'b1111, 8'h55, 64'd62, 1'b1, 1'b1); recv_s(ITER_S);
    send_s(1'b1, 4'b1111, 8'h66, 64'd44, 1'b1, 1'b1); recv_s(ITER_S);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      send_s(1'b0, 4'b0010, 8'(8'hA0 + i), 64'd48, 1'b0, 1'b1);
      recv_s(ITER_S);
      n_checks++;
      if (rdy_s !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_after_take: o_ready=%0b required 1", rdy_s);
      end
    end
  endtask

  task automatic test_backpressure();
    int   n;
    exp_t e;
    ir_s = 1'b0;
    send_s(1'b1, 4'b1000, 8'h5A, 64'd39, 1'b1, 1'b1);
    n = 0;
    while (!ov_s && n < TMO) begin step(); n++; end
    e = q_s.pop_front();
    for (int i = 0; i < 20; i++) begin
      odd_s = 1'b0; man_s = 4'b1111; tag_s = 8'hFF; v_s = 1'b1;
      step();
      n_checks++;
      if (ov_s !== 1'b1 || rdy_s !== 1'b0 || root_s !== e.root[RW_S-1:0] ||
          st_s !== e.sticky || otag_s !== e.tag) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc %0d: ov=%0b rdy=%0b root=%0d st=%0b tag=%h required 1/0/%0d/%0b/%h",
                 i, ov_s, rdy_s, root_s, st_s, otag_s, e.root[RW_S-1:0], e.sticky, e.tag);
      end
    end
    v_s = 1'b0;
    ir_s = 1'b1;
    step();
    n_checks++;
    if (ov_s !== 1'b0 || rdy_s !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: ov=%0b rdy=%0b required 0/1", ov_s, rdy_s);
    end
    send_s(1'b1, 4'b0000, 8'h77, 64'd32, 1'b0, 1'b1); recv_s(ITER_S);
    send_s(1'b0, 4'b0000, 8'h78, 64'd45, 1'b1, 1'b1); recv_s(ITER_S);
  endtask

  task automatic test_reset_mid_busy();
    bit seen;
    send_s(1'b0, 4'b0000, 8'hEE, 64'd45, 1'b1, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    n_checks++;
    if (rdy_s !== 1'b0 || ov_s !== 1'b0 || root_s !== '0 || st_s !== 1'b0 || otag_s !== '0) begin
      n_fail++;
      $display("FAIL reset_busy_outputs: rdy=%0b ov=%0b root=%0d st=%0b tag=%h required all 0",
               rdy_s, ov_s, root_s, st_s, otag_s);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (rdy_s !== 1'b1 || ov_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_release: rdy=%0b ov=%0b required 1/0", rdy_s, ov_s);
    end
    seen = 1'b0;
    for (int i = 0; i < ITER_S + 4; i++) begin
      step();
      if (ov_s !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_busy_discard: o_valid rose=1 required 0");
    end
    send_s(1'b1, 4'b1000, 8'h3C, 64'd39, 1'b1, 1'b1); recv_s(ITER_S);
  endtask

  task automatic test_random_wide();
    logic [63:0]      rnd;
    logic [M_W-1:0]   man;
    logic             odd;
    for (int i = 0; i < N_RAND; i++) begin
      rnd = {32'($urandom), 32'($urandom)};
      man = rnd[M_W-1:0];
      odd = 1'($urandom_range(0, 1));
      if (i < 4) begin
        man = (i[1]) ? '1 : '0;
        odd = i[0];
      end
      send_w(odd, man, 8'($urandom));
      recv_w(ITER_W);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_busy();
    test_random_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
